// File: rtl/matmul_nxn_stream.sv
// +----------------------------------------------------------------------------+
// | Module   : matmul_nxn_stream (with local fp_mul / fp_add units)            |
// | Purpose  : NxN IEEE-754 matrix multiply, one dot product at a time through |
// |            N fp_mul lanes and a pairwise fp_add tree; C streamed row-major.|
// | Options  : MATMUL_ACC_EN adds c_flat and a final "+ C_in" fp_add stage.    |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_mul #(
   parameter int I_EXP  = 8,
   parameter int I_MNT  = 23,
   parameter int I_DATA = I_EXP + I_MNT + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [I_DATA-1:0] a,
   input  logic [I_DATA-1:0] b,
   output logic              out_valid,
   output logic [I_DATA-1:0] y
);
   localparam logic [I_EXP-1:0]        EMAX = '1;
   localparam logic signed [I_EXP+1:0] BIAS = (I_EXP+2)'(2**(I_EXP-1) - 1);

   logic [I_EXP-1:0]        w_ea, w_eb;
   logic [2*I_MNT+1:0]      w_prod;
   logic [I_MNT:0]          w_man;
   logic [I_MNT+1:0]        w_rnd;
   logic signed [I_EXP+1:0] w_exp;
   logic                    w_sgn, w_g, w_s;
   logic [I_DATA-1:0]       w_res;

   // Denormals flush to zero; round to nearest even on the normalised product.
   always_comb begin
      w_sgn  = a[I_DATA-1] ^ b[I_DATA-1];
      w_ea   = a[I_DATA-2:I_MNT];
      w_eb   = b[I_DATA-2:I_MNT];
      w_prod = {1'b1, a[I_MNT-1:0]} * {1'b1, b[I_MNT-1:0]};
      w_exp  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;
      if (w_prod[2*I_MNT+1]) begin
         w_man = w_prod[2*I_MNT+1:I_MNT+1];
         w_g   = w_prod[I_MNT];
         w_s   = |w_prod[I_MNT-1:0];
         w_exp = w_exp + 1;
      end else begin
         w_man = w_prod[2*I_MNT:I_MNT];
         w_g   = w_prod[I_MNT-1];
         w_s   = |w_prod[I_MNT-2:0];
      end
      w_rnd = {1'b0, w_man} + (I_MNT+2)'(w_g & (w_s | w_man[0]));
      if (w_rnd[I_MNT+1]) w_exp = w_exp + 1;
      w_res = {w_sgn, w_exp[I_EXP-1:0], w_rnd[I_MNT-1:0]};
      if (w_exp >= $signed({2'b00, EMAX})) w_res = {w_sgn, EMAX, {I_MNT{1'b0}}};
      else if (w_exp <= 0)                 w_res = {w_sgn, {(I_DATA-1){1'b0}}};
      if (w_ea == '0 || w_eb == '0)        w_res = {w_sgn, {(I_DATA-1){1'b0}}};
      if (w_ea == EMAX || w_eb == EMAX) begin
         if ((w_ea == EMAX && a[I_MNT-1:0] != '0) || (w_eb == EMAX && b[I_MNT-1:0] != '0) ||
             w_ea == '0 || w_eb == '0)
            w_res = {1'b0, EMAX, 1'b1, {(I_MNT-1){1'b0}}};
         else
            w_res = {w_sgn, EMAX, {I_MNT{1'b0}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) y <= w_res;
      end
   end
endmodule

module fp_add #(
   parameter int I_EXP  = 8,
   parameter int I_MNT  = 23,
   parameter int I_DATA = I_EXP + I_MNT + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [I_DATA-1:0] a,
   input  logic [I_DATA-1:0] b,
   output logic              out_valid,
   output logic [I_DATA-1:0] y
);
   localparam int               W    = I_MNT + 4;
   localparam int               LW   = $clog2(W + 1);
   localparam logic [I_EXP-1:0] EMAX = '1;

   logic [I_DATA-1:0]       w_big, w_sml, w_res;
   logic [I_EXP-1:0]        w_d;
   logic [2*W-1:0]          w_shift;
   logic [W-1:0]            w_bm, w_sm, w_norm;
   logic [W:0]              w_sum;
   logic [LW-1:0]           w_lz;
   logic [I_MNT+1:0]        w_rnd;
   logic signed [I_EXP+1:0] w_exp;
   logic                    w_swap, w_sub;

   // Mantissas carry three extra bits (guard, round, sticky) through alignment.
   always_comb begin
      w_swap  = b[I_DATA-2:0] > a[I_DATA-2:0];
      w_big   = w_swap ? b : a;
      w_sml   = w_swap ? a : b;
      w_sub   = w_big[I_DATA-1] ^ w_sml[I_DATA-1];
      w_d     = w_big[I_DATA-2:I_MNT] - w_sml[I_DATA-2:I_MNT];
      w_bm    = {1'b1, w_big[I_MNT-1:0], 3'b000};
      w_shift = {1'b1, w_sml[I_MNT-1:0], 3'b000, {W{1'b0}}} >> w_d;
      w_sm    = w_shift[2*W-1:W];
      w_sm[0] = w_sm[0] | (|w_shift[W-1:0]) | (int'(w_d) >= 2*W);
      w_sum   = w_sub ? ({1'b0, w_bm} - {1'b0, w_sm}) : ({1'b0, w_bm} + {1'b0, w_sm});
      w_lz    = '0;
      for (int i = 0; i < W; i++) if (w_sum[i]) w_lz = LW'(W - 1 - i);
      w_exp   = $signed({2'b00, w_big[I_DATA-2:I_MNT]});
      if (w_sum[W]) begin
         w_norm = {w_sum[W:2], w_sum[1] | w_sum[0]};
         w_exp  = w_exp + 1;
      end else begin
         w_norm = w_sum[W-1:0] << w_lz;
         w_exp  = w_exp - $signed({{(I_EXP+2-LW){1'b0}}, w_lz});
      end
      w_rnd = {1'b0, w_norm[W-1:3]} + (I_MNT+2)'(w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]));
      if (w_rnd[I_MNT+1]) w_exp = w_exp + 1;
      w_res = {w_big[I_DATA-1], w_exp[I_EXP-1:0], w_rnd[I_MNT-1:0]};
      if (w_exp >= $signed({2'b00, EMAX})) w_res = {w_big[I_DATA-1], EMAX, {I_MNT{1'b0}}};
      else if (w_exp <= 0)                 w_res = {w_big[I_DATA-1], {(I_DATA-1){1'b0}}};
      if (w_sum == '0) w_res = '0;
      if (w_sml[I_DATA-2:I_MNT] == '0)
         w_res = (w_big[I_DATA-2:I_MNT] == '0) ?
                 {a[I_DATA-1] & b[I_DATA-1], {(I_DATA-1){1'b0}}} : w_big;
      if (w_big[I_DATA-2:I_MNT] == EMAX) begin
         if (w_big[I_MNT-1:0] != '0 || (w_sub && w_sml[I_DATA-2:I_MNT] == EMAX))
            w_res = {1'b0, EMAX, 1'b1, {(I_MNT-1){1'b0}}};
         else
            w_res = w_big;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) y <= w_res;
      end
   end
endmodule

module matmul_nxn_stream #(
   parameter int N      = 4,
   parameter int I_EXP  = 8,
   parameter int I_MNT  = 23,
   parameter int I_DATA = I_EXP + I_MNT + 1,
   parameter int IDX_W  = (N > 2) ? $clog2(N) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*N*I_DATA-1:0]  a_flat,
   input  logic [N*N*I_DATA-1:0]  b_flat,
`ifdef MATMUL_ACC_EN
   input  logic [N*N*I_DATA-1:0]  c_flat,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [I_DATA-1:0]      out_data,
   output logic [IDX_W-1:0]       out_row,
   output logic [IDX_W-1:0]       out_col,
   output logic                   out_last,
   output logic                   busy
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT} state_t;

   state_t             r_state, w_state_nxt;
   logic [I_DATA-1:0]  r_a [N][N];
   logic [I_DATA-1:0]  r_b [N][N];
   logic [IDX_W-1:0]   r_row, r_col;
   logic [I_DATA-1:0]  r_out_data, w_sum;
   logic               r_in_ready, r_busy;
   logic               w_rst, w_accept, w_issue, w_take, w_done, w_last;
   logic               w_val [1:2*N-1];
   logic [I_DATA-1:0]  w_dat [1:2*N-1];

   assign w_rst     = ~reset;
   assign w_last    = (r_row == IDX_W'(N-1)) && (r_col == IDX_W'(N-1));
   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign out_valid = (r_state == S_PRESENT);
   assign out_last  = out_valid && w_last;
   assign out_data  = r_out_data;
   assign out_row   = r_row;
   assign out_col   = r_col;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_take      = 1'b0;
      case (r_state)
         S_IDLE:    if (in_valid && r_in_ready) begin
                       w_accept    = 1'b1;
                       w_state_nxt = S_ISSUE;
                    end
         S_ISSUE:   begin
                       w_issue     = 1'b1;
                       w_state_nxt = S_WAIT;
                    end
         S_WAIT:    if (w_done) w_state_nxt = S_PRESENT;
         S_PRESENT: if (out_ready) begin
                       w_take      = 1'b1;
                       w_state_nxt = w_last ? S_IDLE : S_ISSUE;
                    end
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_row      <= '0;
         r_col      <= '0;
         r_busy     <= 1'b0;
         r_in_ready <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_in_ready <= (w_state_nxt == S_IDLE);
         if (w_accept) begin
            r_row  <= '0;
            r_col  <= '0;
            r_busy <= 1'b1;
         end
         if (r_state == S_WAIT && w_done) r_out_data <= w_sum;
         if (w_take) begin
            if (w_last) r_busy <= 1'b0;
            else begin
               r_col <= r_col + 1'b1;
               if (r_col == IDX_W'(N-1)) r_row <= r_row + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               r_a[i][k] <= a_flat[(i*N+k)*I_DATA +: I_DATA];
               r_b[i][k] <= b_flat[(i*N+k)*I_DATA +: I_DATA];
            end
         end
      end
   end

   // Heap-indexed tree: leaves N..2N-1 are lane products, node i sums 2i and 2i+1.
   for (genvar k = 0; k < N; k++) begin : g_lane
      fp_mul #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) u_mul (
         .clk(clk), .rst(w_rst), .in_valid(w_issue),
         .a(r_a[r_row][k]), .b(r_b[k][r_col]),
         .out_valid(w_val[N+k]), .y(w_dat[N+k]));
   end

   for (genvar i = 1; i < N; i++) begin : g_tree
      fp_add #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) u_add (
         .clk(clk), .rst(w_rst), .in_valid(w_val[2*i] & w_val[2*i+1]),
         .a(w_dat[2*i]), .b(w_dat[2*i+1]),
         .out_valid(w_val[i]), .y(w_dat[i]));
   end

`ifdef MATMUL_ACC_EN
   logic [I_DATA-1:0] r_c [N][N];

   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
               r_c[i][k] <= c_flat[(i*N+k)*I_DATA +: I_DATA];
      end
   end

   fp_add #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) u_acc (
      .clk(clk), .rst(w_rst), .in_valid(w_val[1]),
      .a(w_dat[1]), .b(r_c[r_row][r_col]),
      .out_valid(w_done), .y(w_sum));
`else
   assign w_done = w_val[1];
   assign w_sum  = w_dat[1];
`endif
endmodule

`default_nettype wire

// File: tb/tb_matmul_nxn_stream.sv
// Directed + randomized bench for matmul_nxn_stream; reference is integer matrix
// arithmetic on exactly-representable values converted to fp32 bit patterns.
`default_nettype none

module tb_matmul_nxn_stream;
   localparam int N  = 4;
   localparam int D  = 32;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [N*N*D-1:0] a_flat = '0;
   logic [N*N*D-1:0] b_flat = '0;
   logic             in_ready, out_valid, out_last, busy;
   logic [D-1:0]     out_data;
   logic [IW-1:0]    out_row, out_col;

   int               tests = 0;
   int               fails = 0;
   int               ia [N][N];
   int               ib [N][N];
   logic [D-1:0]     exp_q [$];

   always #5 clk = ~clk;

   matmul_nxn_stream #(.N(N), .I_EXP(8), .I_MNT(23)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a_flat(a_flat), .b_flat(b_flat),
`ifdef MATMUL_ACC_EN
      .c_flat({(N*N*D){1'b0}}),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy));

   function automatic logic [31:0] int2fp(input int v);
      int          mag, p;
      logic [31:0] r;
      if (v == 0) return 32'h0;
      mag = (v < 0) ? -v : v;
      p   = 0;
      for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'((mag << (23 - p)) & 32'h7FFFFF);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind 0: identity x B(i*N+j); kind 1: all 2.0 x all 1.0; else random nonzero ints
   task automatic gen(input int kind);
      int s, v;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            case (kind)
               0: begin ia[i][k] = (i == k) ? 1 : 0; ib[i][k] = i*N + k; end
               1: begin ia[i][k] = 2; ib[i][k] = 1; end
               default: begin
                  v = int'($urandom_range(1, 7)); ia[i][k] = ($urandom_range(0, 1) == 1) ? -v : v;
                  v = int'($urandom_range(1, 7)); ib[i][k] = ($urandom_range(0, 1) == 1) ? -v : v;
               end
            endcase
            a_flat[(i*N+k)*D +: D] = int2fp(ia[i][k]);
            b_flat[(i*N+k)*D +: D] = int2fp(ib[i][k]);
         end
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += ia[i][k] * ib[k][j];
            exp_q.push_back(int2fp(s));
         end
      end
   endtask

   task automatic send();
      int guard = 0;
      in_valid = 1'b1;
      while (!in_ready && guard < 200) begin
         tick();
         guard++;
      end
      check("accept_wait", guard < 200, 1);
      tick();
      in_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("in_ready_after_accept", in_ready, 0);
   endtask

   task automatic collect(input int stop_at, input bit bp);
      int beat = 0;
      int cyc  = 0;
      int hold = 0;
      while (beat < stop_at && cyc < 3000) begin
         if (bp && out_valid && beat == 4 && hold < 20) begin
            out_ready = 1'b0;
            hold++;
         end else begin
            out_ready = bp ? (cyc % 3 == 0) : 1'b1;
         end
         if (busy) check("in_ready_low_while_busy", in_ready, 0);
         if (out_valid) begin
            check("out_data", out_data, exp_q[0]);
            check("out_row", out_row, beat / N);
            check("out_col", out_col, beat % N);
            if (out_ready) begin
               check("out_last", out_last, beat == N*N-1);
               void'(exp_q.pop_front());
               beat++;
            end
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      check("beats_handed_off", beat, stop_at);
   endtask

   task automatic done_checks();
      check("done_busy", busy, 0);
      check("done_in_ready", in_ready, 1);
      check("done_out_valid", out_valid, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_row", out_row, 0);
      check("rst_out_col", out_col, 0);
      check("rst_out_last", out_last, 0);
      reset = 1'b1;
      tick();
      tick();
      check("idle_in_ready", in_ready, 1);

      gen(0); send(); collect(N*N, 1'b0); done_checks();
      gen(1); check("model_eight", exp_q[0], 32'h41000000);
      send(); collect(N*N, 1'b0); done_checks();
      gen(1); send(); collect(N*N, 1'b1); done_checks();

      // second pair held on in_valid throughout the first job
      gen(2); send();
      gen(2); in_valid = 1'b1;
      collect(N*N, 1'b0);
      done_checks();
      send();
      collect(N*N, 1'b0);
      done_checks();

      // abort while element (2,1) is in flight
      gen(0); send();
      collect(2*N + 1, 1'b0);
      tick();
      check("pre_abort_busy", busy, 1);
      reset = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_out_row", out_row, 0);
      exp_q.delete();
      tick();
      reset = 1'b1;
      tick();
      gen(0); send(); collect(N*N, 1'b0); done_checks();

      for (int j = 0; j < 3; j++) begin
         gen(2); send(); collect(N*N, 1'($urandom_range(0, 1))); done_checks();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
